divider_16b_by_8b_iter: RTL and testbench

- Iterative unsigned divider; performs the inverse operation of the 8x8->16 unsigned multiplier in the arithmetic library.
- Takes a 16-bit dividend and an 8-bit divisor over a val/rdy input stream.
- Produces a 16-bit quotient and an 8-bit remainder over a val/rdy output stream.
- Restoring shift-subtract algorithm, one quotient bit per cycle; sits beside the multiplier in arithmetic-unit datapaths.

---
 rtl/divider_16b_by_8b_iter.sv | 141 ++++++++++++++
 tb/tb_divider_16b_by_8b_iter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_16b_by_8b_iter.sv
// divider_16b_by_8b_iter
//   Iterative unsigned restoring divider. Accepts a DIVIDEND_W-bit dividend and a
//   DIVISOR_W-bit divisor on a val/rdy input stream. Produces the quotient and
//   remainder on a val/rdy output stream, one quotient bit per CALC cycle.
//
//   Optional feature macro: DIVIDER_EARLY_EXIT_EN
//     When defined, operands with in0 < in1 (in1 != 0) skip CALC and finish in
//     one cycle. When undefined, they take the full CALC path and give the same
//     final values.
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   istream_val  operands valid
//   istream_rdy  block can accept operands (state == IDLE)
//   in0          dividend, unsigned
//   in1          divisor, unsigned
//   ostream_val  result valid (state == DONE)
//   ostream_rdy  consumer accepts result
//   quotient     in0 / in1 (all ones when in1 == 0)
//   remainder    in0 % in1 (low bits of in0 when in1 == 0)
//   div_by_zero  result came from in1 == 0
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for operands, istream_rdy = 1
// CALC  | one shift-subtract step per cycle, count steps remaining
// DONE  | result presented, held until ostream_rdy

module divider_16b_by_8b_iter #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  istream_val,
    output logic                  istream_rdy,
    input  logic [DIVIDEND_W-1:0] in0,
    input  logic [DIVISOR_W-1:0]  in1,
    output logic                  ostream_val,
    input  logic                  ostream_rdy,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int CNT_W = $clog2(DIVIDEND_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      count;
    logic [DIVIDEND_W-1:0] dq;         // dividend shifting out, quotient shifting in
    logic [DIVISOR_W-1:0]  rem_r;
    logic [DIVISOR_W-1:0]  divisor_r;
    logic                  dbz_r;

    // Partial remainder after the left shift is DIVISOR_W+1 bits wide. Because
    // it is always below 2*divisor, the top bit of the trial difference is a
    // clean borrow flag: set exactly when shifted < divisor.
    logic [DIVISOR_W:0] shifted;
    logic [DIVISOR_W:0] diff;

    assign shifted = {rem_r, dq[DIVIDEND_W-1]};
    assign diff    = shifted - {1'b0, divisor_r};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            count     <= '0;
            dq        <= '0;
            rem_r     <= '0;
            divisor_r <= '0;
            dbz_r     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (istream_val) begin
                        dq        <= in0;
                        divisor_r <= in1;
                        rem_r     <= '0;
                        count     <= CNT_W'(DIVIDEND_W);
                        dbz_r     <= 1'b0;
                        if (in1 == '0) begin
                            dq    <= '1;
                            rem_r <= in0[DIVISOR_W-1:0];
                            dbz_r <= 1'b1;
                            state <= DONE;
                        end
`ifdef DIVIDER_EARLY_EXIT_EN
                        else if (in0 < DIVIDEND_W'(in1)) begin
                            dq    <= '0;
                            rem_r <= in0[DIVISOR_W-1:0];
                            state <= DONE;
                        end
`endif
                        else begin
                            state <= CALC;
                        end
                    end
                end

                CALC: begin
                    if (diff[DIVISOR_W]) begin
                        rem_r <= shifted[DIVISOR_W-1:0];
                        dq    <= {dq[DIVIDEND_W-2:0], 1'b0};
                    end else begin
                        rem_r <= diff[DIVISOR_W-1:0];
                        dq    <= {dq[DIVIDEND_W-2:0], 1'b1};
                    end
                    count <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        state <= DONE;
                    end
                end

                DONE: begin
                    if (ostream_rdy) begin
                        state <= IDLE;
                        dbz_r <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign istream_rdy = (state == IDLE);
    assign ostream_val = (state == DONE);
    assign quotient    = dq;
    assign remainder   = rem_r;
    assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_divider_16b_by_8b_iter.sv
// tb_divider_16b_by_8b_iter
//   Self-checking bench for divider_16b_by_8b_iter. A queue of expected results
//   is filled from plain arithmetic on each accepted operand pair; a single
//   negedge monitor compares handshake signals and result fields every cycle.
//   Directed operations also carry hand-computed literal results.

module tb_divider_16b_by_8b_iter;

    logic        clk;
    logic        reset_n;
    logic        istream_val;
    logic        istream_rdy;
    logic [15:0] in0;
    logic [7:0]  in1;
    logic        ostream_val;
    logic        ostream_rdy;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    divider_16b_by_8b_iter #(
        .DIVIDEND_W(16),
        .DIVISOR_W (8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .istream_val(istream_val),
        .istream_rdy(istream_rdy),
        .in0        (in0),
        .in1        (in1),
        .ostream_val(ostream_val),
        .ostream_rdy(ostream_rdy),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    typedef struct {
        int          acc;
        int          lat;
        logic [15:0] q;
        logic [7:0]  r;
        logic        dbz;
        bit          lit;
        logic [15:0] lq;
        logic [7:0]  lr;
        logic        ld;
    } exp_t;

    exp_t eq[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit bp_rand = 0;

    bit          nxt_lit;
    logic [15:0] nxt_lq;
    logic [7:0]  nxt_lr;
    logic        nxt_ld;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [7:0] b, input int acc);
        exp_t e;
        e.acc = acc;
        e.lit = 0;
        e.lq  = '0;
        e.lr  = '0;
        e.ld  = 1'b0;
        if (b == 8'd0) begin
            e.q   = 16'hFFFF;
            e.r   = a[7:0];
            e.dbz = 1'b1;
            e.lat = 1;
        end else begin
            e.q   = a / {8'd0, b};
            e.r   = 8'(a % {8'd0, b});
            e.dbz = 1'b0;
`ifdef DIVIDER_EARLY_EXIT_EN
            e.lat = (a < {8'd0, b}) ? 1 : 17;
`else
            e.lat = 17;
`endif
        end
        return e;
    endfunction

    // Single compare process: handshake every cycle, result fields whenever valid.
    always @(negedge clk) begin
        bit   exp_rdy;
        bit   exp_val;
        exp_t e;
        if (reset_n) begin
            exp_rdy = (eq.size() == 0);
            exp_val = (eq.size() != 0) && (cyc >= eq[0].acc + eq[0].lat);
            chk("istream_rdy", 32'(istream_rdy), 32'(exp_rdy));
            chk("ostream_val", 32'(ostream_val), 32'(exp_val));
            if (exp_val) begin
                chk("quotient",    32'(quotient),    32'(eq[0].q));
                chk("remainder",   32'(remainder),   32'(eq[0].r));
                chk("div_by_zero", 32'(div_by_zero), 32'(eq[0].dbz));
                if (eq[0].lit) begin
                    chk("lit_quotient",    32'(quotient),    32'(eq[0].lq));
                    chk("lit_remainder",   32'(remainder),   32'(eq[0].lr));
                    chk("lit_div_by_zero", 32'(div_by_zero), 32'(eq[0].ld));
                end
                if (ostream_rdy) void'(eq.pop_front());
            end
            if (istream_val && exp_rdy) begin
                e     = model(in0, in1, cyc);
                e.lit = nxt_lit;
                e.lq  = nxt_lq;
                e.lr  = nxt_lr;
                e.ld  = nxt_ld;
                eq.push_back(e);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (bp_rand) ostream_rdy = ($urandom_range(0, 2) != 0);
    end

    task automatic send(input logic [15:0] a, input logic [7:0] b, input bit lit,
                        input logic [15:0] lq, input logic [7:0] lr, input logic ld);
        int n = 0;
        while (!istream_rdy && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 300) chk("send_timeout", 32'(n), 32'(0));
        nxt_lit     = lit;
        nxt_lq      = lq;
        nxt_lr      = lr;
        nxt_ld      = ld;
        istream_val = 1'b1;
        in0         = a;
        in1         = b;
        @(posedge clk);
        #1;
        istream_val = 1'b0;
        nxt_lit     = 0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (eq.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 300) chk("result_timeout", 32'(eq.size()), 32'(0));
    endtask

    initial begin
        reset_n     = 1'b0;
        istream_val = 1'b0;
        in0         = '0;
        in1         = '0;
        ostream_rdy = 1'b1;
        nxt_lit     = 0;
        nxt_lq      = '0;
        nxt_lr      = '0;
        nxt_ld      = 1'b0;

        repeat (3) @(posedge clk);
        #2;
        chk("rst_ostream_val", 32'(ostream_val), 32'(0));
        chk("rst_quotient",    32'(quotient),    32'(0));
        chk("rst_remainder",   32'(remainder),   32'(0));
        chk("rst_div_by_zero", 32'(div_by_zero), 32'(0));
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases with hand-computed results.
        send(16'd1000, 8'd7, 1, 16'd142, 8'd6, 1'b0);
        wait_done();
        send(16'hFFFF, 8'hFF, 1, 16'h0101, 8'd0, 1'b0);
        wait_done();
        send(16'hFFFF, 8'h01, 1, 16'hFFFF, 8'd0, 1'b0);
        wait_done();
        send(16'h1234, 8'h00, 1, 16'hFFFF, 8'h34, 1'b1);
        wait_done();
        send(16'h0010, 8'h04, 1, 16'd4, 8'd0, 1'b0);
        wait_done();
        send(16'd5, 8'd9, 1, 16'd0, 8'd5, 1'b0);
        wait_done();
        send(16'd0, 8'd37, 1, 16'd0, 8'd0, 1'b0);
        wait_done();

        // Backpressure: hold result 10+ cycles while istream_val pulses are ignored.
        ostream_rdy = 1'b0;
        send(16'd300, 8'd16, 1, 16'd18, 8'd12, 1'b0);
        for (int i = 0; i < 27; i++) begin
            istream_val = 1'b1;
            in0         = 16'($urandom);
            in1         = 8'($urandom);
            @(posedge clk);
            #1;
        end
        istream_val = 1'b0;
        ostream_rdy = 1'b1;
        wait_done();
        @(posedge clk);
        #1;

        // Reset in the middle of CALC.
        send(16'hABCD, 8'd5, 0, '0, '0, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrst_ostream_val", 32'(ostream_val), 32'(0));
        chk("midrst_quotient",    32'(quotient),    32'(0));
        chk("midrst_remainder",   32'(remainder),   32'(0));
        chk("midrst_div_by_zero", 32'(div_by_zero), 32'(0));
        chk("midrst_istream_rdy", 32'(istream_rdy), 32'(1));
        eq.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        send(16'd200, 8'd3, 1, 16'd66, 8'd2, 1'b0);
        wait_done();

        // Randomized operations with random backpressure.
        bp_rand = 1;
        for (int i = 0; i < 60; i++) begin
            logic [15:0] a;
            logic [7:0]  b;
            a = 16'($urandom);
            b = 8'($urandom);
            case ($urandom_range(0, 5))
                0: b = 8'd0;
                1: a = 16'($urandom_range(0, 300));
                2: b = 8'd1;
                default: ;
            endcase
            send(a, b, 0, '0, '0, 1'b0);
        end
        wait_done();
        bp_rand = 0;
        ostream_rdy = 1'b1;
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
